// File: rtl/reg_file.sv
// Multi-ported register file: two combinational read ports, one byte-masked write
// port with optional same-cycle forwarding, and a hardware clear sweep.
module reg_file #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(DEPTH),
  localparam int BW    = WIDTH / 8
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [BW-1:0]    wr_be,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             clr,
  output logic             busy,
  output logic             done,
  output logic             wr_drop
);

  typedef enum logic {IDLE, SWEEP} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic             done_q, done_d;
  logic             wr_drop_q, wr_drop_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  function automatic logic [WIDTH-1:0] byte_merge(input logic [WIDTH-1:0] old_w,
                                                  input logic [WIDTH-1:0] new_w,
                                                  input logic [BW-1:0]    be);
    logic [WIDTH-1:0] r;
    r = old_w;
    for (int b = 0; b < BW; b++)
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // Write and clr on the same edge in IDLE: the write lands first, the sweep clears it later.
  always_comb begin
    mem_d     = mem_q;
    state_d   = state_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    wr_drop_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_en && wr_addr != '0)
          mem_d[wr_addr] = byte_merge(mem_q[wr_addr], wr_data, wr_be);
        if (clr) begin
          state_d = SWEEP;
          idx_d   = AW'(1);
        end
      end
      SWEEP: begin
        wr_drop_d     = wr_en;
        mem_d[idx_q]  = '0;
        if (idx_q == AW'(DEPTH - 1)) begin
          state_d = IDLE;
          idx_d   = AW'(1);
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    mem_d[0] = '0;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= IDLE;
      idx_q     <= AW'(1);
      done_q    <= 1'b0;
      wr_drop_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
      wr_drop_q <= wr_drop_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  // Forwarding only applies to a write that will actually be accepted this edge.
  logic fwd_ok;
  assign fwd_ok = (BYPASS != 0) && wr_en && (state_q == IDLE) && (wr_addr != '0);

  always_comb begin
    rd_data_a = mem_q[rd_addr_a];
    rd_data_b = mem_q[rd_addr_b];
    if (fwd_ok && rd_addr_a == wr_addr) rd_data_a = byte_merge(mem_q[rd_addr_a], wr_data, wr_be);
    if (fwd_ok && rd_addr_b == wr_addr) rd_data_b = byte_merge(mem_q[rd_addr_b], wr_data, wr_be);
    if (rd_addr_a == '0) rd_data_a = '0;
    if (rd_addr_b == '0) rd_data_b = '0;
  end

  assign busy    = (state_q == SWEEP);
  assign done    = done_q;
  assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: a forwarding and a non-forwarding instance share stimulus and
// are checked each cycle against an array model, plus directed literal checks.
module tb_reg_file;
  localparam int W = 32, D = 32, AWL = 5, BWL = 4;

  logic CLK = 1'b0, RSTn = 1'b1;
  always #5 CLK = ~CLK;

  logic [AWL-1:0] rd_addr_a = '0, rd_addr_b = '0, wr_addr = '0;
  logic [BWL-1:0] wr_be = '0;
  logic [W-1:0]   wr_data = '0;
  logic           wr_en = 1'b0, clr = 1'b0;
  logic [W-1:0]   rda1, rdb1, rda0, rdb0;
  logic           busy1, done1, drop1, busy0, done0, drop0;

  reg_file #(.WIDTH(W), .DEPTH(D), .BYPASS(1)) dut1 (
    .CLK(CLK), .RSTn(RSTn), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rda1), .rd_data_b(rdb1), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_be(wr_be), .wr_data(wr_data), .clr(clr), .busy(busy1), .done(done1),
    .wr_drop(drop1));

  reg_file #(.WIDTH(W), .DEPTH(D), .BYPASS(0)) dut0 (
    .CLK(CLK), .RSTn(RSTn), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rda0), .rd_data_b(rdb0), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_be(wr_be), .wr_data(wr_data), .clr(clr), .busy(busy0), .done(done0),
    .wr_drop(drop0));

  int errors = 0, checks = 0;
  bit cmp_en = 1'b0;

  // Model: contents, whether a sweep is running and which entry it clears next.
  logic [W-1:0] m [D];
  bit sweeping = 1'b0, m_done = 1'b0, m_drop = 1'b0;
  int sw_idx = 1;
  initial for (int i = 0; i < D; i++) m[i] = '0;

  function automatic logic [W-1:0] merge(input logic [W-1:0] o, input logic [W-1:0] d,
                                         input logic [BWL-1:0] be);
    logic [W-1:0] r;
    r = o;
    for (int b = 0; b < BWL; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [W-1:0] exp_rd(input logic [AWL-1:0] a, input bit byp);
    if (a == 0) return '0;
    if (byp && wr_en && !sweeping && a == wr_addr) return merge(m[a], wr_data, wr_be);
    return m[a];
  endfunction

  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < D; i++) m[i] <= '0;
      sweeping <= 1'b0; m_done <= 1'b0; m_drop <= 1'b0; sw_idx <= 1;
    end else begin
      m_done <= 1'b0;
      m_drop <= 1'b0;
      if (sweeping) begin
        m_drop    <= wr_en;
        m[sw_idx] <= '0;
        if (sw_idx == D - 1) begin sweeping <= 1'b0; m_done <= 1'b1; end
        else sw_idx <= sw_idx + 1;
      end else begin
        if (wr_en && wr_addr != 0) m[wr_addr] <= merge(m[wr_addr], wr_data, wr_be);
        if (clr) begin sweeping <= 1'b1; sw_idx <= 1; end
      end
    end
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) if (cmp_en) begin
    chk("model_rd_a_byp", rda1, exp_rd(rd_addr_a, 1'b1));
    chk("model_rd_b_byp", rdb1, exp_rd(rd_addr_b, 1'b1));
    chk("model_rd_a_nobyp", rda0, exp_rd(rd_addr_a, 1'b0));
    chk("model_rd_b_nobyp", rdb0, exp_rd(rd_addr_b, 1'b0));
    chk("model_busy", {busy1, busy0}, {2{sweeping}});
    chk("model_done", {done1, done0}, {2{m_done}});
    chk("model_wr_drop", {drop1, drop0}, {2{m_drop}});
  end

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic wr(input logic [AWL-1:0] a, input logic [W-1:0] d, input logic [BWL-1:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    step();
    wr_en = 1'b0;
  endtask

  function automatic logic [W-1:0] fillv(input int i);
    return {8'(i), 8'hA5, 8'(i + 3), 8'h5A};
  endfunction

  int busy_cnt, done_cnt;

  initial begin
    #1 RSTn = 1'b0;
    cmp_en = 1'b1;
    repeat (2) step();
    chk("reset_busy", {31'b0, busy1}, 0);
    chk("reset_done", {31'b0, done1}, 0);
    chk("reset_drop", {31'b0, drop1}, 0);
    rd_addr_a = 5; #1 chk("reset_rd", rda1, 0);
    step(); RSTn = 1'b1;
    step();

    // Basic write and register 0
    wr(5, 32'hFFFF1111, 4'hF);
    rd_addr_a = 5; #1 chk("basic_wr_r5", rda1, 32'hFFFF1111);
    wr(0, 32'h12345678, 4'hF);
    rd_addr_a = 0; #1 chk("wr_r0_reads0", rda1, 32'h0);
    wr(5, 32'h0BAD0BAD, 4'h0);
    rd_addr_a = 5; #1 chk("be0_nochange", rda1, 32'hFFFF1111);
    chk("be0_no_drop", {31'b0, drop1}, 0);

    // Byte enables
    wr(3, 32'h12345678, 4'hF);
    wr(3, 32'hAABBCCDD, 4'b0101);
    rd_addr_a = 3; #1 chk("byte_en_r3", rda1, 32'h12BB56DD);

    // Forwarding vs none
    wr_en = 1'b1; wr_addr = 7; wr_data = 32'h00010001; wr_be = 4'hF; rd_addr_b = 7;
    #1 chk("fwd_byp1", rdb1, 32'h00010001);
    chk("fwd_byp0", rdb0, 32'h0);
    step(); wr_en = 1'b0;
    #1 chk("after_edge_byp0", rdb0, 32'h00010001);

    // Full sweep with a rejected write and an ignored clr
    for (int i = 1; i < D; i++) wr(AWL'(i), fillv(i), 4'hF);
    clr = 1'b1; step(); clr = 1'b0;
    busy_cnt = 0; done_cnt = 0; rd_addr_a = 20;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (busy1) busy_cnt++;
      if (done1) done_cnt++;
      if (c == 5) begin wr_en = 1'b1; wr_addr = 20; wr_data = 32'hDEADBEEF; wr_be = 4'hF; end
      if (c == 6) begin
        wr_en = 1'b0;
        chk("sweep_wr_drop", {31'b0, drop1}, 1);
        #1 chk("sweep_wr_nochange", rda1, fillv(20));
      end
      if (c == 8) clr = 1'b1;
      if (c == 9) clr = 1'b0;
      step();
    end
    chk("sweep_busy_cycles", busy_cnt, 31);
    chk("sweep_done_count", done_cnt, 1);
    for (int i = 1; i < D; i++) begin
      rd_addr_a = AWL'(i); #1 chk("sweep_cleared", rda1, 0);
    end
    step();

    // Reset in the middle of a sweep
    for (int i = 1; i < D; i++) wr(AWL'(i), fillv(i), 4'hF);
    clr = 1'b1; step(); clr = 1'b0;
    repeat (9) step();
    RSTn = 1'b0;
    #1 chk("rst_mid_busy", {31'b0, busy1}, 0);
    for (int i = 1; i < D; i++) begin
      rd_addr_a = AWL'(i); #1 chk("rst_mid_cleared", rda1, 0);
    end
    step(); RSTn = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin #1 if (done1) done_cnt++; step(); end
    chk("rst_mid_no_done", done_cnt, 0);

    // Simultaneous clr and write
    wr(4, 32'h0000000F, 4'hF);
    wr_en = 1'b1; wr_addr = 4; wr_data = 32'hF0010001; wr_be = 4'hF; clr = 1'b1;
    step(); wr_en = 1'b0; clr = 1'b0; rd_addr_a = 4;
    for (int c = 0; c < 35; c++) begin
      #1;
      if (c == 0) chk("simul_c0", rda1, 32'hF0010001);
      if (c == 3) chk("simul_c3", rda1, 32'hF0010001);
      if (c == 4) chk("simul_c4", rda1, 32'h0);
      step();
    end

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
